// File: rtl/five_switch_debouncer.sv
// Five-channel switch conditioner: 2-flop synchroniser plus a per-channel
// stability counter feeding registered A..E levels, a change strobe and a busy flag.
module five_switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] SW,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       CHG,
  output logic       BUSY
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0]       sync_q1;
  logic [4:0]       sync_q2;
  logic [4:0]       out_q;
  logic [4:0]       out_d;
  logic             chg_q;
  logic [CNT_W-1:0] cnt_q [5];
  logic [CNT_W-1:0] cnt_d [5];

  // Filter: a channel follows its synchronised switch only after the switch
  // has disagreed with the output for DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    out_d = out_q;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_q2[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LAST_COUNT) begin
        out_d[i] = sync_q2[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      out_q   <= '0;
      chg_q   <= 1'b0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      sync_q1 <= SW;
      sync_q2 <= sync_q1;
      out_q   <= out_d;
      chg_q   <= (out_d != out_q);
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // CHG is a valid-only strobe for the A..E vector: high for exactly the first
  // cycle a new vector is presented, with no ready; consumers sample it then.
  always_comb begin
    BUSY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (cnt_q[i] != '0) BUSY = 1'b1;
    end
  end

  assign A   = out_q[4];
  assign B   = out_q[3];
  assign C   = out_q[2];
  assign D   = out_q[1];
  assign E   = out_q[0];
  assign CHG = chg_q;

endmodule

// File: tb/tb_five_switch_debouncer.sv
// Bench for five_switch_debouncer: directed test-plan scenarios plus random
// switch activity, checked against a sliding-window reference model.
module tb_five_switch_debouncer;

  localparam int DEB   = 4;
  localparam int CNT_W = 4;

  logic       clk;
  logic       rst;
  logic [4:0] SW;
  logic       A, B, C, D, E, CHG, BUSY;

  int checks;
  int errors;
  int chg_cnt;
  bit checking;

  logic [4:0] exp_q[$];

  five_switch_debouncer #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .SW(SW),
    .A(A), .B(B), .C(C), .D(D), .E(E),
    .CHG(CHG), .BUSY(BUSY)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Per edge, record the switch value as captured by the first sync stage
  // (0 on reset edges) and whether the edge was a reset edge. The value a
  // channel filter sees at edge e is the capture from edge e-2, zero if edge
  // e-1 was a reset. An output flips at edge k when the filtered value at
  // every edge in k-DEB+1..k (none of them reset edges) differs from it.
  logic [4:0] samp_q[$];
  bit         rst_h[$];
  logic [4:0] m_out;
  logic       m_chg;
  logic       m_busy;

  function automatic logic [4:0] seen_at(int e);
    if (e < 2) return 5'b0;
    if (rst_h[e-1]) return 5'b0;
    return samp_q[e-2];
  endfunction

  initial begin
    m_out = '0; m_chg = 1'b0; m_busy = 1'b0;
  end

  always @(posedge clk) begin
    int k;
    logic [4:0] nxt;
    logic busy;
    samp_q.push_back(rst ? 5'b0 : SW);
    rst_h.push_back(rst);
    k = samp_q.size() - 1;
    if (rst) begin
      m_out = '0; m_chg = 1'b0; m_busy = 1'b0;
    end else begin
      nxt  = m_out;
      busy = 1'b0;
      for (int ch = 0; ch < 5; ch++) begin
        bit flip;
        flip = 1'b1;
        for (int j = 0; j < DEB; j++) begin
          int e;
          e = k - j;
          if (e < 0) flip = 1'b0;
          else if (rst_h[e] || seen_at(e)[ch] == m_out[ch]) flip = 1'b0;
        end
        if (flip) nxt[ch] = ~m_out[ch];
        else if (seen_at(k)[ch] != m_out[ch]) busy = 1'b1;
      end
      m_chg = (nxt != m_out);
      if (m_chg) exp_q.push_back(nxt);
      m_out  = nxt;
      m_busy = busy;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle levels against the model, and each CHG strobe pops
  // the scoreboard and compares the presented vector.
  always @(negedge clk) begin
    if (checking) begin
      check("levels", {27'b0, A, B, C, D, E}, {27'b0, m_out});
      check("chg", {31'b0, CHG}, {31'b0, m_chg});
      check("busy", {31'b0, BUSY}, {31'b0, m_busy});
      if (CHG === 1'b1) begin
        chg_cnt++;
        if (exp_q.size() == 0) begin
          check("chg_unexpected", 32'd1, 32'd0);
        end else begin
          logic [4:0] want;
          want = exp_q.pop_front();
          check("chg_vector", {27'b0, A, B, C, D, E}, {27'b0, want});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle_zero();
    SW = 5'b0;
    tick(12);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int snap;
    checks = 0; errors = 0; chg_cnt = 0; checking = 1'b0;
    rst = 1'b1;
    SW  = 5'b11111;

    // 1: reset with switches set
    tick(1);
    checking = 1'b1;
    tick(2);
    check("reset_levels", {27'b0, A, B, C, D, E}, 32'd0);
    check("reset_busy", {31'b0, BUSY}, 32'd0);
    rst = 1'b0;
    settle_zero();

    // 2: single channel rise
    snap = chg_cnt;
    SW = 5'b10000;
    tick(12);
    check("rise_A", {31'b0, A}, 32'd1);
    check("rise_others", {28'b0, B, C, D, E}, 32'd0);
    check("rise_chg_count", chg_cnt - snap, 32'd1);

    // 3: glitch rejection on SW[3]
    snap = chg_cnt;
    SW[3] = 1'b1;
    tick(3);
    SW[3] = 1'b0;
    tick(10);
    check("glitch_B", {31'b0, B}, 32'd0);
    check("glitch_no_chg", chg_cnt - snap, 32'd0);

    // 4: multi-bit vector
    settle_zero();
    snap = chg_cnt;
    SW = 5'b10101;
    tick(20);
    check("vector_levels", {27'b0, A, B, C, D, E}, 32'b10101);
    check("vector_one_chg", chg_cnt - snap, 32'd1);

    // 5: reset mid-count
    settle_zero();
    SW = 5'b11111;
    tick(2);
    rst = 1'b1;
    tick(2);
    check("midrst_levels", {27'b0, A, B, C, D, E}, 32'd0);
    rst = 1'b0;
    tick(12);
    check("midrst_all_high", {27'b0, A, B, C, D, E}, 32'b11111);

    // 6: bounce on release of SW[4]
    snap = chg_cnt;
    for (int t = 0; t < 5; t++) begin
      SW[4] = ~SW[4];
      tick(2);
    end
    tick(12);
    check("bounce_A_low", {31'b0, A}, 32'd0);
    check("bounce_one_chg", chg_cnt - snap, 32'd1);

    // random activity, occasional resets
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 1) == 0) SW = 5'($urandom_range(0, 31));
      else SW[$urandom_range(0, 4)] = ~SW[$urandom_range(0, 4)];
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        tick($urandom_range(1, 3));
        rst = 1'b0;
      end
      tick($urandom_range(1, 8));
    end
    tick(12);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/five_switch_debouncer.md
Name: five_switch_debouncer

Overview:
Upstream input stage for the five-input combinational logic block. It conditions five raw board switches into clean, registered A..E levels that drive that block directly. Each switch is synchronised, then filtered by its own stability counter, so the downstream F output never sees metastable values or contact bounce. A change strobe and a busy flag let a monitor or display stage know when the input vector has settled.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles required before an output follows its switch (10 ms at 100 MHz). Legal range is 1 .. 2**CNT_W-1; the value 0 is illegal.
CNT_W, 20, width of each per-channel stability counter.

Ports:
clk  input  1  single system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
SW  input  5  raw asynchronous switches: SW[4]->A, SW[3]->B, SW[2]->C, SW[1]->D, SW[0]->E.
A  output  1  debounced SW[4], registered.
B  output  1  debounced SW[3], registered.
C  output  1  debounced SW[2], registered.
D  output  1  debounced SW[1], registered.
E  output  1  debounced SW[0], registered.
CHG  output  1  one-cycle strobe, high in the first cycle any of A..E shows a new value.
BUSY  output  1  high while any channel counter is non-zero.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - Both synchroniser flop stages, all counters, A..E and CHG are cleared to 0.
  - BUSY therefore reads 0.
  - SW is ignored while rst is high.
- Synchroniser: a 2-flop chain per bit produces s[i]. Only s[i] feeds the filter.
- Per-channel filter, evaluated at every edge with rst low. Let out[i] be the current debounced output.
  - If s[i] == out[i]: the counter is cleared to 0.
  - Else if counter == DEBOUNCE_CYCLES-1: out[i] takes s[i] and the counter is cleared to 0.
  - Else: the counter increments by 1.
  - The counter never wraps, because the legal DEBOUNCE_CYCLES range keeps it within CNT_W.
- Latency: SW changes before edge t0 and stays stable. The new value is visible on the output after edge t0+DEBOUNCE_CYCLES+1 (2 synchroniser edges plus DEBOUNCE_CYCLES-1 counting edges).
- Glitch rejection: any return of s[i] to out[i] before the count completes clears that counter. A pulse shorter than DEBOUNCE_CYCLES synchronised cycles never reaches the output.
- Channel independence: the channels are fully independent.
  - Simultaneous switch changes on several channels update on the same edge and produce one CHG pulse.
  - Staggered changes produce one CHG pulse per distinct update edge.
- CHG is registered. It is set on the same edge that any out[i] updates and cleared on the next edge unless another update occurs then. CHG is never high for a cycle in which A..E did not change.
- BUSY is combinational: the OR of (counter[i] != 0) over all channels. It carries no state of its own.
- Reset mid-count: partial counts are discarded and the outputs return to 0. After rst falls, a held switch re-qualifies with the full latency, counted from the first edge with rst low as t0.
- Outputs only ever move from one stable level to the other: at most one transition per channel per DEBOUNCE_CYCLES cycles.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and CNT_W=4.
1. Reset with switches set: SW=5'b11111, rst high for 3 edges -> A..E=0, CHG=0, BUSY=0 throughout.
2. Single channel rise: after reset, SW goes 00000->10000 before edge t0 and is held -> A=1 from edge t0+5 onward; CHG high exactly one cycle at t0+5; B..E=0; BUSY high between edges t0+2 and t0+5 only.
3. Glitch rejection: SW[3] high for 3 cycles, then low -> B stays 0, CHG never asserts, BUSY pulses then returns to 0.
4. Multi-bit vector: SW=5'b10101 held 20 cycles -> A, C, E rise on the same edge t0+5; exactly one CHG pulse; B=D=0.
5. Reset mid-count: SW=11111, then rst asserted 2 cycles after the change and released 2 cycles later -> all outputs 0 during reset; all five rise 5 edges after the first rst-low edge.
6. Bounce on release: A=1, then SW[4] toggles every 2 cycles for 10 cycles before settling at 0 -> A falls exactly once, 5 edges after the last transition, with a single CHG pulse.
